carregador_programa: RTL and testbench

- DMA-style program loader that copies a process image from the simulated HD into that process's partition of instruction memory.
- It drives the instruction memory write port (InstrWrite/ender/dado), which is otherwise idle, and the HD read address (trilha/setor).
- Invoked by the OS scheduler before a process is first dispatched.
- Sits directly upstream of memoria_de_instrucoes, and downstream of HD for reads.

---
 rtl/carregador_programa.sv | 133 +++++++++++++
 tb/tb_carregador_programa.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// Program loader: copies a process image from the HD into that process's
// instruction-memory partition, one word every HD_LAT+1 cycles.
module carregador_programa #(
  parameter int ADDR_W       = 10,
  parameter int BASE_MI      = 100,
  parameter int TAM_PARTICAO = 150,
  parameter int HD_LAT       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  input  logic [1:0]        id_proc,
  input  logic [3:0]        trilha,
  input  logic [5:0]        setor_ini,
  input  logic [7:0]        num_palavras,
  output logic [3:0]        hd_trilha,
  output logic [5:0]        hd_setor,
  input  logic [31:0]       hd_dado,
  output logic              instr_write,
  output logic [ADDR_W-1:0] instr_ender,
  output logic [31:0]       instr_dado,
  output logic              ocupado,
  output logic              pronto,
  output logic              erro,
  output logic [7:0]        palavras_copiadas,
  output logic [1:0]        estado_dbg
);

  // Handshake: inicio is accepted only in OCIOSO (no queuing); every accepted
  // inicio, legal or not, is answered by exactly one single-cycle pronto pulse.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t           estado;
  logic [1:0]        id_reg;
  logic [7:0]        n_reg;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic              ilegal;
  logic [7:0]        proxima;
  logic              fim_disco;

  assign estado_dbg = estado;

  always_comb begin
    base      = ADDR_W'(BASE_MI) + ADDR_W'(id_reg - 2'd1) * ADDR_W'(TAM_PARTICAO);
    ilegal    = (id_proc == 2'd0) || (num_palavras == 8'd0) ||
                (int'(num_palavras) > TAM_PARTICAO);
    proxima   = palavras_copiadas + 8'd1;
    fim_disco = (hd_trilha == 4'd15) && (hd_setor == 6'd63);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado            <= OCIOSO;
      id_reg            <= '0;
      n_reg             <= '0;
      cnt               <= '0;
      hd_trilha         <= '0;
      hd_setor          <= '0;
      instr_write       <= 1'b0;
      instr_ender       <= '0;
      instr_dado        <= '0;
      ocupado           <= 1'b0;
      pronto            <= 1'b0;
      erro              <= 1'b0;
      palavras_copiadas <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          pronto <= 1'b0;
          if (inicio) begin
            palavras_copiadas <= '0;
            if (ilegal) begin
              erro   <= 1'b1;
              estado <= FIM;
            end else begin
              id_reg    <= id_proc;
              n_reg     <= num_palavras;
              hd_trilha <= trilha;
              hd_setor  <= setor_ini;
              erro      <= 1'b0;
              ocupado   <= 1'b1;
              cnt       <= '0;
              estado    <= ESPERA;
            end
          end
        end
        ESPERA: begin
          if (cnt == 3'(HD_LAT - 1)) begin
            instr_dado  <= hd_dado;
            instr_ender <= base + ADDR_W'(palavras_copiadas);
            instr_write <= 1'b1;
            estado      <= ESCREVE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ESCREVE: begin
          instr_write       <= 1'b0;
          palavras_copiadas <= proxima;
          if (proxima == n_reg) begin
            estado <= FIM;
          end else if (fim_disco) begin
            // Ran off the last sector with words still owed: partial count stays.
            erro   <= 1'b1;
            estado <= FIM;
          end else begin
            if (hd_setor == 6'd63) begin
              hd_setor  <= '0;
              hd_trilha <= hd_trilha + 4'd1;
            end else begin
              hd_setor <= hd_setor + 6'd1;
            end
            cnt    <= '0;
            estado <= ESPERA;
          end
        end
        FIM: begin
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: load vectors table, busy re-start,
// HD_LAT=3 spacing and asynchronous reset during a write.
module tb_carregador_programa;
  localparam int ADDR_W = 10;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DUT with HD_LAT=1
  logic              inicio;
  logic [1:0]        id_proc;
  logic [3:0]        trilha;
  logic [5:0]        setor_ini;
  logic [7:0]        num_palavras;
  logic [3:0]        hd_trilha;
  logic [5:0]        hd_setor;
  logic [31:0]       hd_dado;
  logic              instr_write;
  logic [ADDR_W-1:0] instr_ender;
  logic [31:0]       instr_dado;
  logic              ocupado, pronto, erro;
  logic [7:0]        palavras_copiadas;
  logic [1:0]        estado_dbg;

  // DUT with HD_LAT=3
  logic              l3_inicio;
  logic [1:0]        l3_id_proc;
  logic [3:0]        l3_trilha;
  logic [5:0]        l3_setor_ini;
  logic [7:0]        l3_num_palavras;
  logic [3:0]        l3_hd_trilha;
  logic [5:0]        l3_hd_setor;
  logic [31:0]       l3_hd_dado;
  logic              l3_instr_write;
  logic [ADDR_W-1:0] l3_instr_ender;
  logic [31:0]       l3_instr_dado;
  logic              l3_ocupado, l3_pronto, l3_erro;
  logic [7:0]        l3_palavras_copiadas;
  logic [1:0]        l3_estado_dbg;

  carregador_programa #(.ADDR_W(ADDR_W), .BASE_MI(100), .TAM_PARTICAO(150), .HD_LAT(1)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .id_proc(id_proc), .trilha(trilha),
    .setor_ini(setor_ini), .num_palavras(num_palavras), .hd_trilha(hd_trilha),
    .hd_setor(hd_setor), .hd_dado(hd_dado), .instr_write(instr_write),
    .instr_ender(instr_ender), .instr_dado(instr_dado), .ocupado(ocupado),
    .pronto(pronto), .erro(erro), .palavras_copiadas(palavras_copiadas),
    .estado_dbg(estado_dbg)
  );

  carregador_programa #(.ADDR_W(ADDR_W), .BASE_MI(100), .TAM_PARTICAO(150), .HD_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset), .inicio(l3_inicio), .id_proc(l3_id_proc), .trilha(l3_trilha),
    .setor_ini(l3_setor_ini), .num_palavras(l3_num_palavras), .hd_trilha(l3_hd_trilha),
    .hd_setor(l3_hd_setor), .hd_dado(l3_hd_dado), .instr_write(l3_instr_write),
    .instr_ender(l3_instr_ender), .instr_dado(l3_instr_dado), .ocupado(l3_ocupado),
    .pronto(l3_pronto), .erro(l3_erro), .palavras_copiadas(l3_palavras_copiadas),
    .estado_dbg(l3_estado_dbg)
  );

  // HD content: low byte 0xA0+sector, track in the top nibble
  function automatic logic [31:0] hd_word(input logic [3:0] t, input logic [5:0] s);
    return {t, 20'h0, 8'hA0 + {2'b00, s}};
  endfunction

  assign hd_dado    = hd_word(hd_trilha, hd_setor);
  assign l3_hd_dado = hd_word(l3_hd_trilha, l3_hd_setor);

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // write monitor: every write must match the head of exp_q and last one cycle
  logic prev_write = 1'b0;
  always @(negedge clk) begin
    if (instr_write) begin
      check("write_pulse_width", 64'(prev_write), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({instr_ender, instr_dado}), 64'hDEAD);
      end else begin
        check("write_addr_data", 64'({instr_ender, instr_dado}), 64'(exp_q.pop_front()));
      end
    end
    prev_write = instr_write;
  end

  // driver
  task automatic start(input logic [1:0] id, input logic [3:0] tr, input logic [5:0] se,
                       input logic [7:0] n);
    @(negedge clk);
    id_proc = id; trilha = tr; setor_ini = se; num_palavras = n; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio       = 1'b0;
    id_proc      = 2'($urandom_range(0, 3));
    trilha       = 4'($urandom_range(0, 15));
    setor_ini    = 6'($urandom_range(0, 63));
    num_palavras = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_pronto(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (pronto) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic push_expected(input int base, input int count, input logic [3:0] tr,
                               input logic [5:0] se);
    logic [3:0] t;
    logic [5:0] s;
    t = tr; s = se;
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({ADDR_W'(base + i), hd_word(t, s)});
      if (s == 6'd63) begin
        s = 6'd0;
        t = t + 4'd1;
      end else begin
        s = s + 6'd1;
      end
    end
  endtask

  typedef struct {
    logic [1:0] id;
    logic [3:0] tr;
    logic [5:0] se;
    logic [7:0] n;
    int         exp_base;
    int         exp_count;
    logic       exp_erro;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc;
    int w_cyc[$];
    int p_cyc;
    logic seen;

    vecs[0] = '{2'd1, 4'd2,  6'd5,  8'd3,   100, 3,   1'b0, 7};
    vecs[1] = '{2'd3, 4'd0,  6'd0,  8'd2,   400, 2,   1'b0, 5};
    vecs[2] = '{2'd2, 4'd1,  6'd0,  8'd150, 250, 150, 1'b0, 301};
    vecs[3] = '{2'd3, 4'd3,  6'd10, 8'd150, 400, 150, 1'b0, 301};
    vecs[4] = '{2'd1, 4'd4,  6'd62, 8'd4,   100, 4,   1'b0, 9};
    vecs[5] = '{2'd2, 4'd15, 6'd63, 8'd2,   250, 1,   1'b1, 3};
    vecs[6] = '{2'd0, 4'd1,  6'd0,  8'd5,   0,   0,   1'b1, 1};
    vecs[7] = '{2'd1, 4'd1,  6'd0,  8'd0,   100, 0,   1'b1, 1};
    vecs[8] = '{2'd1, 4'd1,  6'd0,  8'd151, 100, 0,   1'b1, 1};
    vecs[9] = '{2'd1, 4'd0,  6'd0,  8'd1,   100, 1,   1'b0, 3};

    inicio = 0; id_proc = 0; trilha = 0; setor_ini = 0; num_palavras = 0;
    l3_inicio = 0; l3_id_proc = 0; l3_trilha = 0; l3_setor_ini = 0; l3_num_palavras = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_instr_write", 64'(instr_write), 64'd0);
    check("reset_ocupado", 64'(ocupado), 64'd0);
    check("reset_pronto", 64'(pronto), 64'd0);
    check("reset_erro", 64'(erro), 64'd0);
    check("reset_palavras", 64'(palavras_copiadas), 64'd0);
    check("reset_estado", 64'(estado_dbg), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // table of loads
    for (int v = 0; v < 10; v++) begin
      push_expected(vecs[v].exp_base, vecs[v].exp_count, vecs[v].tr, vecs[v].se);
      start(vecs[v].id, vecs[v].tr, vecs[v].se, vecs[v].n);
      check($sformatf("v%0d_ocupado_start", v), 64'(ocupado), 64'(vecs[v].exp_cycles > 1));
      wait_pronto(cyc);
      check($sformatf("v%0d_pronto_cycle", v), 64'(cyc), 64'(vecs[v].exp_cycles));
      check($sformatf("v%0d_erro", v), 64'(erro), 64'(vecs[v].exp_erro));
      check($sformatf("v%0d_palavras", v), 64'(palavras_copiadas), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_ocupado_end", v), 64'(ocupado), 64'd0);
      check($sformatf("v%0d_writes_left", v), 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pronto_single", v), 64'(pronto), 64'd0);
      check($sformatf("v%0d_erro_hold", v), 64'(erro), 64'(vecs[v].exp_erro));
      exp_q.delete();
    end

    // inicio re-pulsed mid-load is ignored
    push_expected(100, 3, 4'd2, 6'd5);
    start(2'd1, 4'd2, 6'd5, 8'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    id_proc = 2'd3; trilha = 4'd7; setor_ini = 6'd1; num_palavras = 8'd2; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    wait_pronto(cyc);
    check("busy_pronto_cycle", 64'(cyc + 3), 64'd7);
    check("busy_palavras", 64'(palavras_copiadas), 64'd3);
    check("busy_erro", 64'(erro), 64'd0);
    check("busy_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_requeue", 64'(estado_dbg), 64'd0);

    // HD_LAT=3: writes 4 cycles apart
    @(negedge clk);
    l3_id_proc = 2'd1; l3_trilha = 4'd0; l3_setor_ini = 6'd0; l3_num_palavras = 8'd2;
    l3_inicio = 1'b1;
    @(posedge clk);
    #1;
    l3_inicio = 1'b0;
    p_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (l3_instr_write) begin
        w_cyc.push_back(c);
        check("l3_write", 64'({l3_instr_ender, l3_instr_dado}),
              64'({ADDR_W'(100 + w_cyc.size() - 1), hd_word(4'd0, 6'(w_cyc.size() - 1))}));
      end
      if (l3_pronto) begin
        p_cyc = c;
        break;
      end
    end
    check("l3_write_count", 64'(w_cyc.size()), 64'd2);
    if (w_cyc.size() == 2) begin
      check("l3_write0_cycle", 64'(w_cyc[0]), 64'd3);
      check("l3_write1_cycle", 64'(w_cyc[1]), 64'd7);
    end
    check("l3_pronto_cycle", 64'(p_cyc), 64'd9);
    check("l3_palavras", 64'(l3_palavras_copiadas), 64'd2);

    // asynchronous reset while instr_write is high
    push_expected(250, 5, 4'd0, 6'd0);
    start(2'd2, 4'd0, 6'd0, 8'd5);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (instr_write) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_write_seen", 64'(seen), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_instr_write", 64'(instr_write), 64'd0);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_pronto", 64'(pronto), 64'd0);
    check("rst_erro", 64'(erro), 64'd0);
    check("rst_palavras", 64'(palavras_copiadas), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_idle_estado", 64'(estado_dbg), 64'd0);
    check("rst_idle_ocupado", 64'(ocupado), 64'd0);
    check("rst_idle_palavras", 64'(palavras_copiadas), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
